// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall controller
package pipe_ctrl_pkg;
  typedef enum logic {RUN, DWAIT} state_t;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;
  localparam int CNT_W_DEF = 16;
  localparam int MAX_WAIT_DEF = 255;
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard/memory handshakes in, stage enables and bubbles out
interface pipe_stall_ctrl_if;
  logic       nostall;
  logic [1:0] pcsource;
  logic       m_mem_acc;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req;
  logic       dmem_req;
  logic       wpcir;
  logic       ifid_bubble;
  logic       idex_bubble;
  logic       pipe_en;
  logic       mwb_bubble;
  modport master (
    input  nostall, pcsource, m_mem_acc, imem_ack, dmem_ack,
    output imem_req, dmem_req, wpcir, ifid_bubble, idex_bubble, pipe_en, mwb_bubble
  );
  modport slave (
    output nostall, pcsource, m_mem_acc, imem_ack, dmem_ack,
    input  imem_req, dmem_req, wpcir, ifid_bubble, idex_bubble, pipe_en, mwb_bubble
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stage enables, bubbles and stall counters for the 5-stage pipe
// Define BRANCH_FLUSH_EN to squash delay-slot fetches and add flush_cnt.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             clrn,
  pipe_stall_ctrl_if.master bus,
  output logic             timeout,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mem_cnt
`ifdef BRANCH_FLUSH_EN
  ,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  state_t     state;
  logic       imem_req_q;
  logic [7:0] wait_cnt;
  logic       acc, dstall, lu, fpend, flush, wait_inc;
  // Gating with clrn keeps requests low while reset is held.
  assign acc      = bus.m_mem_acc & clrn;
  assign dstall   = (state == DWAIT) | (acc & ~bus.dmem_ack);
  assign lu       = ~dstall & ~bus.nostall;
  assign fpend    = ~dstall & bus.nostall & ~bus.imem_ack;
  assign wait_inc = dstall | fpend;
`ifdef BRANCH_FLUSH_EN
  assign flush = ~dstall & bus.nostall & bus.imem_ack & (bus.pcsource != PC_SEQ);
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .clrn(clrn), .inc(flush), .q(flush_cnt));
`else
  logic unused_pcsource;
  assign unused_pcsource = ^bus.pcsource;
  assign flush = 1'b0;
`endif
  assign bus.imem_req    = imem_req_q;
  assign bus.dmem_req    = (state == DWAIT) | acc;
  assign bus.wpcir       = ~dstall & bus.nostall & bus.imem_ack;
  assign bus.pipe_en     = ~dstall;
  assign bus.mwb_bubble  = dstall;
  assign bus.idex_bubble = lu;
  assign bus.ifid_bubble = fpend | flush;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state      <= RUN;
      imem_req_q <= 1'b0;
      wait_cnt   <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= (state == RUN) ? ((acc && !bus.dmem_ack) ? DWAIT : RUN)
                                   : (bus.dmem_ack ? RUN : DWAIT);
      imem_req_q <= 1'b1;
      wait_cnt   <= wait_inc ? ((&wait_cnt) ? wait_cnt : wait_cnt + 8'd1) : 8'd0;
      timeout    <= timeout | (wait_inc && wait_cnt == 8'(MAX_WAIT - 1));
    end
  sat_counter #(.W(CNT_W)) u_lu  (.clk(clk), .clrn(clrn), .inc(lu),       .q(lu_cnt));
  sat_counter #(.W(CNT_W)) u_mem (.clk(clk), .clrn(clrn), .inc(wait_inc), .q(mem_cnt));
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage pipelined CPU. It takes the ID-stage hazard verdict (nostall), the ID-stage branch decision (pcsource) and ready/ack handshakes from multi-cycle instruction and data memories. It generates all stage-register enables and bubble/flush strobes, plus saturating stall counters. It sits beside the ID stage and drives the IF/ID, ID/EX, EX/MEM and MEM/WB latches.

Parameters:
CNT_W, 16, width of each saturating performance counter
MAX_WAIT, 255, memory-wait cycles before timeout flag; 8-bit field

Ports:
clk  in  1  system clock, all flops rising edge
clrn  in  1  asynchronous active-low reset
nostall  in  1  from ID control unit; 0 = load-use hazard this cycle
pcsource  in  2  from ID control unit; 00 = sequential, any other value = taken branch/jump
m_mem_acc  in  1  MEM stage holds a load or store (wmem or m2reg)
imem_ack  in  1  instruction memory: fetch data valid this cycle
dmem_ack  in  1  data memory: access complete this cycle
imem_req  out  1  fetch request, held until acked
dmem_req  out  1  data access request, held until acked
wpcir  out  1  PC and IF/ID write enable
ifid_bubble  out  1  load NOP into IF/ID
idex_bubble  out  1  zero wreg/wmem/m2reg/jal into ID/EX
pipe_en  out  1  ID/EX and EX/MEM write enable
mwb_bubble  out  1  zero wwreg into MEM/WB
timeout  out  1  sticky; a memory wait exceeded MAX_WAIT
lu_cnt  out  CNT_W  load-use stall cycles
mem_cnt  out  CNT_W  memory wait cycles, I and D combined

Behaviour:
- Reset, asynchronous on clrn=0:
  - state=RUN; imem_req=0, dmem_req=0, timeout=0, counters=0, wait counter=0.
  - Combinational outputs fall back to their RUN values with no requests.
- First clk edge after reset release: imem_req=1.
- States: RUN, DWAIT.
  - RUN -> DWAIT when m_mem_acc=1 and dmem_ack=0.
  - DWAIT -> RUN on the dmem_ack=1 cycle.
- Request outputs:
  - dmem_req = m_mem_acc, combinational in RUN, forced 1 in DWAIT.
  - imem_req = 1 except during reset.
  - An acked fetch completes in the same cycle.
- Output priority, evaluated every cycle:
  1. Data stall (state=DWAIT, or RUN with m_mem_acc=1 and dmem_ack=0): wpcir=0, pipe_en=0, ifid_bubble=0, idex_bubble=0, mwb_bubble=1. The whole front freezes.
  2. Else load-use (nostall=0): wpcir=0, pipe_en=1, idex_bubble=1, ifid_bubble=0. IF/ID holds its instruction.
  3. Else fetch pending (imem_ack=0): wpcir=0, pipe_en=1, ifid_bubble=1. The ID instruction proceeds.
  4. Else: wpcir=1, pipe_en=1, all bubbles 0.
- mwb_bubble=0 in every case except case 1.
- Wait counter:
  - Increments each cycle that case 1 or case 3 holds; clears when neither holds.
  - Reaching MAX_WAIT sets timeout. timeout stays set until reset.
- Counters saturate at all-ones and never wrap.
  - lu_cnt increments in case 2.
  - mem_cnt increments in cases 1 and 3.
- Branches are delayed: the delay-slot instruction executes. pcsource only affects the optional feature.
- dmem_ack while m_mem_acc=0 in RUN is ignored.

Optional Feature:
BRANCH_FLUSH_EN
- Defined:
  - When pcsource != 00 in case 4, ifid_bubble=1 in that cycle, squashing the delay-slot fetch. wpcir stays 1.
  - Adds output flush_cnt [CNT_W] counting squashes, saturating.
- Undefined:
  - pcsource is unused.
  - flush_cnt is not present.
  - Delay-slot semantics are unchanged.

Decomposition:
- Package pipe_ctrl_pkg:
  - state encoding RUN/DWAIT.
  - pcsource encodings: PC_SEQ=2'b00, PC_BR=2'b01, PC_JR=2'b10, PC_J=2'b11.
  - Default CNT_W.
- One sub-module, sat_counter (parameterised width, inc, async clrn): instantiated for lu_cnt, mem_cnt, and flush_cnt when enabled.

Test Plan:
- Reset with clrn=0 mid-DWAIT, during which dmem_req=1 -> same cycle: dmem_req=0, state RUN, lu_cnt=0, timeout=0.
- nostall=0 for 1 cycle, imem_ack=1, no mem access -> that cycle: wpcir=0, idex_bubble=1, pipe_en=1; next cycle wpcir=1; lu_cnt=1.
- m_mem_acc=1, dmem_ack low 3 cycles then high -> 3 cycles of pipe_en=0, wpcir=0, mwb_bubble=1; 4th cycle (ack) still frozen, then RUN; mem_cnt=4; dmem_req high for 4 cycles.
- Data stall plus nostall=0 plus imem_ack=0 together -> data-stall outputs only (idex_bubble=0, ifid_bubble=0); lu_cnt unchanged.
- imem_ack=0 for 256 cycles -> ifid_bubble=1 throughout; timeout rises at wait count 255 and stays set after ack; mem_cnt=256.
- With BRANCH_FLUSH_EN, pcsource=01 and otherwise clean -> ifid_bubble=1, wpcir=1, flush_cnt=1. Without it, the same stimulus gives ifid_bubble=0.
